// File: rtl/seq_pipe_delay_nstage_if.sv
// Bus bundle for the N-stage delay line. The master drives the stimulus side
// and the slave (the pipeline) drives the tap and occupancy side.
interface seq_pipe_delay_nstage_if #(
    parameter int NBITS   = 8,
    parameter int NSTAGES = 4,
    parameter int SELW    = $clog2(NSTAGES + 1)
);
    logic [NBITS-1:0] in_;
    logic             in_val;
    logic             en;
    logic             flush;
    logic [SELW-1:0]  dsel;
    logic [NBITS-1:0] out;
    logic             out_val;
    logic [SELW-1:0]  count;

    modport master (
        output in_, in_val, en, flush, dsel,
        input  out, out_val, count
    );

    modport slave (
        input  in_, in_val, en, flush, dsel,
        output out, out_val, count
    );
endinterface

// File: rtl/seq_pipe_delay_nstage.sv
// Stallable, flushable N-stage delay line with a valid bit per stage, a
// runtime output tap (0 = bypass, k = stage k) and live occupancy count.
// Stage data is kept at zero whenever its valid bit is clear, so taps never
// need extra masking.
module seq_pipe_delay_nstage #(
    parameter int NBITS   = 8,
    parameter int NSTAGES = 4,
    parameter int SELW    = $clog2(NSTAGES + 1)
) (
    input logic                   clk,
    input logic                   reset,
    seq_pipe_delay_nstage_if.slave bus
);

    logic [NSTAGES:1]            stg_v_q, stg_v_d;
    logic [NSTAGES:1][NBITS-1:0] stg_d_q, stg_d_d;

    logic             out_val_c;
    logic [NBITS-1:0] out_c;
    logic [SELW-1:0]  cnt_c;

    // Next-state: flush beats advance; a stall holds everything and drops input.
    always_comb begin
        stg_v_d = stg_v_q;
        stg_d_d = stg_d_q;
        if (bus.flush) begin
            stg_v_d = '0;
            stg_d_d = '0;
        end else if (bus.en) begin
            stg_v_d[1] = bus.in_val;
            stg_d_d[1] = bus.in_val ? bus.in_ : '0;
            for (int k = 2; k <= NSTAGES; k++) begin
                stg_v_d[k] = stg_v_q[k-1];
                stg_d_d[k] = stg_d_q[k-1];
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_v_q <= '0;
            stg_d_q <= '0;
        end else begin
            stg_v_q <= stg_v_d;
            stg_d_q <= stg_d_d;
        end
    end

    // Output tap mux; selections past the last stage read as empty.
    always_comb begin
        out_val_c = 1'b0;
        out_c     = '0;
        if (bus.dsel == '0) begin
            out_val_c = bus.in_val;
            out_c     = bus.in_val ? bus.in_ : '0;
        end else if (bus.dsel <= SELW'(NSTAGES)) begin
            out_val_c = stg_v_q[bus.dsel];
            out_c     = stg_d_q[bus.dsel];
        end
    end

    // Occupancy: population count of stage valid bits (bypass excluded).
    always_comb begin
        cnt_c = '0;
        for (int k = 1; k <= NSTAGES; k++) begin
            cnt_c = cnt_c + SELW'(stg_v_q[k]);
        end
    end

    assign bus.out     = out_c;
    assign bus.out_val = out_val_c;
    assign bus.count   = cnt_c;

endmodule

// File: tb/tb_seq_pipe_delay_nstage.sv
// Directed bench for the N-stage delay line. Two instances (4 and 5 stages)
// share the stimulus; a queue model of each pipe is compared on every
// negedge, and hand-computed literals pin the key scenarios.
module tb_seq_pipe_delay_nstage;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_;
    logic       in_val, en, flush;
    logic [2:0] dsel;

    always #5 clk = ~clk;

    seq_pipe_delay_nstage_if #(.NBITS(8), .NSTAGES(4)) ifa ();
    seq_pipe_delay_nstage_if #(.NBITS(8), .NSTAGES(5)) ifb ();

    assign ifa.in_ = in_;  assign ifa.in_val = in_val; assign ifa.en = en;
    assign ifa.flush = flush; assign ifa.dsel = dsel;
    assign ifb.in_ = in_;  assign ifb.in_val = in_val; assign ifb.en = en;
    assign ifb.flush = flush; assign ifb.dsel = dsel;

    seq_pipe_delay_nstage #(.NBITS(8), .NSTAGES(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    seq_pipe_delay_nstage #(.NBITS(8), .NSTAGES(5)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;
    bit model_ok = 1'b0;
    // Model pipes: element 0 is stage 1; -1 marks an empty stage.
    int qa[$];
    int qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tap(input int q[$], input int n, input int ds, input int iv, input int id);
        if (ds == 0) return iv ? id : -1;
        if (ds <= n) return q[ds-1];
        return -1;
    endfunction

    function automatic int occ(input int q[$]);
        int c = 0;
        foreach (q[i]) if (q[i] != -1) c++;
        return c;
    endfunction

    // Model update on the active edge.
    initial forever begin
        @(posedge clk);
        if (reset || (flush && model_ok)) begin
            qa.delete(); qb.delete();
            for (int i = 0; i < 4; i++) qa.push_back(-1);
            for (int i = 0; i < 5; i++) qb.push_back(-1);
            if (reset) model_ok = 1'b1;
        end else if (en && model_ok) begin
            qa.push_front(in_val ? int'(in_) : -1); void'(qa.pop_back());
            qb.push_front(in_val ? int'(in_) : -1); void'(qb.pop_back());
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        int ea, eb;
        @(negedge clk);
        if (model_ok) begin
            ea = tap(qa, 4, int'(dsel), int'(in_val), int'(in_));
            eb = tap(qb, 5, int'(dsel), int'(in_val), int'(in_));
            chk("model_a_out", 32'(ifa.out), 32'(ea < 0 ? 0 : ea));
            chk("model_a_val", 32'(ifa.out_val), 32'(ea >= 0));
            chk("model_a_cnt", 32'(ifa.count), 32'(occ(qa)));
            chk("model_b_out", 32'(ifb.out), 32'(eb < 0 ? 0 : eb));
            chk("model_b_val", 32'(ifb.out_val), 32'(eb >= 0));
            chk("model_b_cnt", 32'(ifb.count), 32'(occ(qb)));
        end
    end

    task automatic drive(input logic [7:0] d, input logic v, input logic e,
                         input logic f, input logic r, input logic [2:0] s);
        in_ = d; in_val = v; en = e; flush = f; reset = r; dsel = s;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic samp;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] bd [5];
        logic       bv [5];
        int         so [9];
        bd = '{8'h11, 8'hff, 8'h33, 8'h00, 8'h00};
        bv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        so = '{0, 0, 0, 1, 1, 1, 2, 3, 0};

        // Reset state.
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4); tick;
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4); samp;
        chk("rst_out", 32'(ifa.out), 32'h0);
        chk("rst_val", 32'(ifa.out_val), 32'h0);
        chk("rst_cnt", 32'(ifa.count), 32'd0);
        tick;

        // Reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            drive(8'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0, 3'd4); tick;
        end
        drive(8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4); samp;
        chk("pre_rst_cnt", 32'(ifa.count), 32'd4);
        chk("pre_rst_out", 32'(ifa.out), 32'h01);
        tick;
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4); samp;
        chk("mid_rst_cnt", 32'(ifa.count), 32'd0);
        chk("mid_rst_out", 32'(ifa.out), 32'h0);
        tick;

        // Fixed latency at dsel=4.
        for (int c = 0; c < 10; c++) begin
            drive(c < 6 ? 8'(10 + c) : 8'h00, c < 6, 1'b1, 1'b0, 1'b0, 3'd4); samp;
            chk("lat_out", 32'(ifa.out), c >= 4 ? 32'(10 + c - 4) : 32'h0);
            if (c <= 6) chk("lat_cnt", 32'(ifa.count), 32'(c < 4 ? c : 4));
            tick;
        end

        // Bubbles and zero forcing at dsel=2.
        for (int c = 0; c < 5; c++) begin
            drive(bd[c], bv[c], 1'b1, 1'b0, 1'b0, 3'd2); samp;
            if (c >= 2) begin
                chk("bub_out", 32'(ifa.out), bv[c-2] ? 32'(bd[c-2]) : 32'h0);
                chk("bub_val", 32'(ifa.out_val), 32'(bv[c-2]));
            end
            chk("bub_cnt_le2", 32'(ifa.count <= 3'd2), 32'd1);
            tick;
        end
        drive(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3); tick;

        // Stall at dsel=3.
        for (int c = 0; c < 9; c++) begin
            if (c < 3)      drive(8'(c + 1), 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
            else if (c < 5) drive(8'haa, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
            else            drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
            samp;
            chk("stall_out", 32'(ifa.out), 32'(so[c]));
            chk("stall_no_aa", 32'(ifa.out == 8'haa), 32'd0);
            if (c >= 3 && c <= 5) chk("stall_cnt", 32'(ifa.count), 32'd3);
            tick;
        end

        // Flush of a full pipe.
        for (int c = 0; c < 4; c++) begin
            drive(8'(c + 1), 1'b1, 1'b1, 1'b0, 1'b0, 3'd4); tick;
        end
        drive(8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4); samp;
        chk("fl_full_cnt", 32'(ifa.count), 32'd4);
        tick;
        for (int s = 1; s <= 4; s++) begin
            drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'(s)); samp;
            chk("fl_out", 32'(ifa.out), 32'h0);
            chk("fl_val", 32'(ifa.out_val), 32'h0);
            chk("fl_cnt", 32'(ifa.count), 32'd0);
            tick;
        end
        for (int c = 0; c < 5; c++) begin
            drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4); samp;
            chk("fl_no_55", 32'(ifa.out == 8'h55), 32'd0);
            tick;
        end

        // Runtime tap sweep on a stalled pipe holding 01..04.
        for (int c = 0; c < 4; c++) begin
            drive(8'(c + 1), 1'b1, 1'b1, 1'b0, 1'b0, 3'd4); tick;
        end
        for (int s = 0; s < 8; s++) begin
            drive(8'h9c, 1'b1, 1'b0, 1'b0, 1'b0, 3'(s)); samp;
            chk("tap_out", 32'(ifa.out), s == 0 ? 32'h9c : (s <= 4 ? 32'(5 - s) : 32'h0));
            chk("tap_val", 32'(ifa.out_val), 32'(s <= 4));
            if (s == 7) begin
                chk("b_sel7_out", 32'(ifb.out), 32'h0);
                chk("b_sel7_val", 32'(ifb.out_val), 32'h0);
            end
            tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
